// File: rtl/johnson_phase_sequencer.sv
// Johnson-counter phase sequencer: start/stop/pause control, bounded or free-running
// bursts in either direction, phase decode and illegal-code recovery.
module johnson_phase_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int PH_W  = 3
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 dir,
    input  logic [CNT_W-1:0]     burst_len,
    output logic [WIDTH-1:0]     q_out,
    output logic [PH_W-1:0]      phase,
    output logic [2*WIDTH-1:0]   phase_oh,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   q_step;
    logic [WIDTH-2:0]   edges;
    logic               legal;
    logic [PH_W-1:0]    pop;

    // Legal Johnson codes have at most one 0/1 boundary between adjacent bits.
    assign edges = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
    assign legal = $onehot0(edges);

    assign q_step = dir_q ? {~q_q[0], q_q[WIDTH-1:1]}
                          : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PH_W'(q_q[i]);
        end
    end

    always_comb begin
        phase = '0;
        if (q_q[0]) begin
            phase = pop;
        end else if (pop != '0) begin
            phase = PH_W'(2 * WIDTH) - pop;
        end
    end

    assign phase_oh = {{(2*WIDTH-1){1'b0}}, 1'b1} << phase;
    assign q_out    = q_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done     = done_q;
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (!legal) begin
            q_d   = '0;
            err_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_RUN;
                        dir_d   = dir;
                        rem_d   = burst_len;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (pause) begin
                        state_d = S_HOLD;
                    end else begin
                        q_d = q_step;
                        // rem of zero means free-run: never counts down
                        if (rem_q != '0) begin
                            rem_d = rem_q - 1'b1;
                            if (rem_q == CNT_W'(1)) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (!pause) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed bench for johnson_phase_sequencer: reset, bursts, free-run,
// reverse, pause/ignored start and illegal-code recovery.
module tb_johnson_phase_sequencer;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            clear_n;
    logic            start, stop, pause, dir;
    logic [CW-1:0]   burst_len;
    logic [W-1:0]    q_out;
    logic [PW-1:0]   phase;
    logic [2*W-1:0]  phase_oh;
    logic            busy, done, err;

    int vec  = 0;
    int errs = 0;

    johnson_phase_sequencer #(.WIDTH(W), .CNT_W(CW), .PH_W(PW)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .stop(stop),
        .pause(pause), .dir(dir), .burst_len(burst_len), .q_out(q_out),
        .phase(phase), .phase_oh(phase_oh), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clear_n = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;
        burst_len = '0;
        #2;
        clear_n = 1'b1;
        tick();
    endtask

    task automatic go(input logic d, input logic [CW-1:0] n);
        dir = d;
        burst_len = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; dir = 1'b0;
        burst_len = '0;
        #1;
        vec++;
        if (q_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errs++;
            $display("FAIL rst_vals got q=%b busy=%b done=%b err=%b want 0000/0/0/0",
                     q_out, busy, done, err);
        end
        vec++;
        if (phase !== 3'd0 || phase_oh !== 8'b00000001) begin
            errs++;
            $display("FAIL rst_phase got %0d/%b want 0/00000001", phase, phase_oh);
        end
        #2 clear_n = 1'b1;
        tick();
        go(1'b0, 8'd5);
        tick();
        tick();
        vec++;
        if (q_out !== 4'b0011 || busy !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre got q=%b busy=%b want 0011/1", q_out, busy);
        end
        #3 clear_n = 1'b0;
        #1;
        vec++;
        if (q_out !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL rst_async got q=%b busy=%b done=%b want 0000/0/0",
                     q_out, busy, done);
        end
        #2 clear_n = 1'b1;
        tick();
        go(1'b0, 8'd2);
        tick();
        vec++;
        if (q_out !== 4'b0001 || done !== 1'b0) begin
            errs++;
            $display("FAIL rst_b1 got q=%b done=%b want 0001/0", q_out, done);
        end
        tick();
        vec++;
        if (q_out !== 4'b0011 || done !== 1'b1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_b2 got q=%b done=%b busy=%b want 0011/1/0",
                     q_out, done, busy);
        end
    endtask

    task automatic test_forward;
        logic [W-1:0] exp_q [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
        do_reset();
        go(1'b0, 8'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if (q_out !== exp_q[i] || done !== (i == 4)) begin
                errs++;
                $display("FAIL fwd_step%0d got q=%b done=%b want %b/%0d",
                         i, q_out, done, exp_q[i], (i == 4));
            end
        end
        vec++;
        if (phase !== 3'd5 || phase_oh !== 8'b00100000 || busy !== 1'b0) begin
            errs++;
            $display("FAIL fwd_end got ph=%0d oh=%b busy=%b want 5/00100000/0",
                     phase, phase_oh, busy);
        end
        tick();
        vec++;
        if (done !== 1'b0 || busy !== 1'b0 || q_out !== 4'b1110) begin
            errs++;
            $display("FAIL fwd_after got done=%b busy=%b q=%b want 0/0/1110",
                     done, busy, q_out);
        end
    endtask

    task automatic test_freerun;
        logic [W-1:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000};
        logic saw_done = 1'b0;
        do_reset();
        go(1'b0, 8'd0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            saw_done |= done;
            vec++;
            if (q_out !== seq[k % 8] || busy !== 1'b1) begin
                errs++;
                $display("FAIL free_step%0d got q=%b busy=%b want %b/1",
                         k, q_out, busy, seq[k % 8]);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        saw_done |= done;
        vec++;
        if (busy !== 1'b0 || q_out !== 4'b0011 || saw_done !== 1'b0) begin
            errs++;
            $display("FAIL free_stop got busy=%b q=%b done_seen=%b want 0/0011/0",
                     busy, q_out, saw_done);
        end
        tick();
        tick();
        vec++;
        if (q_out !== 4'b0011 || done !== 1'b0) begin
            errs++;
            $display("FAIL free_hold got q=%b done=%b want 0011/0", q_out, done);
        end
    endtask

    task automatic test_reverse;
        logic [W-1:0]  exp_q  [3] = '{4'b1000, 4'b1100, 4'b1110};
        logic [PW-1:0] exp_ph [3] = '{3'd7, 3'd6, 3'd5};
        do_reset();
        go(1'b1, 8'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            dir = (i == 0) ? 1'b0 : 1'b1;
            vec++;
            if (q_out !== exp_q[i] || phase !== exp_ph[i] || done !== (i == 2)) begin
                errs++;
                $display("FAIL rev_step%0d got q=%b ph=%0d done=%b want %b/%0d/%0d",
                         i, q_out, phase, done, exp_q[i], exp_ph[i], (i == 2));
            end
        end
    endtask

    task automatic test_pause;
        logic [W-1:0] exp_q [4] = '{4'b0111, 4'b1111, 4'b1110, 4'b1100};
        int n_done = 0;
        do_reset();
        go(1'b0, 8'd6);
        tick();
        tick();
        vec++;
        if (q_out !== 4'b0011) begin
            errs++;
            $display("FAIL pause_pre got q=%b want 0011", q_out);
        end
        pause = 1'b1;
        start = 1'b1;
        dir = 1'b1;
        burst_len = 8'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec++;
            if (q_out !== 4'b0011 || busy !== 1'b1 || done !== 1'b0) begin
                errs++;
                $display("FAIL pause_hold%0d got q=%b busy=%b done=%b want 0011/1/0",
                         i, q_out, busy, done);
            end
        end
        pause = 1'b0;
        tick();
        vec++;
        if (q_out !== 4'b0011 || busy !== 1'b1) begin
            errs++;
            $display("FAIL pause_resume got q=%b busy=%b want 0011/1", q_out, busy);
        end
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            tick();
            if (done === 1'b1) n_done++;
            vec++;
            if (q_out !== exp_q[i]) begin
                errs++;
                $display("FAIL pause_adv%0d got q=%b want %b", i, q_out, exp_q[i]);
            end
        end
        start = 1'b0;
        dir = 1'b0;
        tick();
        if (done === 1'b1) n_done++;
        vec++;
        if (n_done != 1 || busy !== 1'b0 || q_out !== 4'b1100) begin
            errs++;
            $display("FAIL pause_end got dones=%0d busy=%b q=%b want 1/0/1100",
                     n_done, busy, q_out);
        end
    endtask

    task automatic test_illegal;
        logic [W-1:0] exp_q [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        do_reset();
        go(1'b0, 8'd6);
        tick();
        tick();
        force dut.q_q = 4'b0101;
        #1 release dut.q_q;
        vec++;
        if (q_out !== 4'b0101 || err !== 1'b0) begin
            errs++;
            $display("FAIL ill_inject got q=%b err=%b want 0101/0", q_out, err);
        end
        tick();
        vec++;
        if (q_out !== 4'b0000 || err !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL ill_recover got q=%b err=%b busy=%b want 0000/1/1",
                     q_out, err, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (q_out !== exp_q[i] || err !== 1'b0 || done !== (i == 3)) begin
                errs++;
                $display("FAIL ill_cont%0d got q=%b err=%b done=%b want %b/0/%0d",
                         i, q_out, err, done, exp_q[i], (i == 3));
            end
        end
        go(1'b0, 8'd2);
        tick();
        vec++;
        if (q_out !== 4'b1110 || done !== 1'b0) begin
            errs++;
            $display("FAIL ill_next1 got q=%b done=%b want 1110/0", q_out, done);
        end
        tick();
        vec++;
        if (q_out !== 4'b1100 || done !== 1'b1 || err !== 1'b0) begin
            errs++;
            $display("FAIL ill_next2 got q=%b done=%b err=%b want 1100/1/0",
                     q_out, done, err);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_freerun();
        test_reverse();
        test_pause();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
